// File: rtl/screen_scaler_renderer.sv
// -----------------------------------------------------------------------------
// screen_scaler_renderer
//
// Full-screen indexed image renderer on vga_clk. Scales an SRC_W x SRC_H image
// up to the DISP_W x DISP_H active area with column/row DDA step counters (no
// dividers), picks one of NUM_SCREENS images stacked in one ROM, and emits a
// registered 4-bit RGB pixel three clocks after DrawX/DrawY.
//
// Pipeline:
//   c0  DrawX/DrawY/blank sampled, DDA and address computed
//   c1  rom_addr registered
//   c2  rom_q valid, palette lookup (pal_idx = rom_q)
//   c3  red/green/blue registered
//
// Optional feature macro: SCREEN_FADE_EN
//   defined   : fade FSM (SHOWN/FADE_OUT/DARK/FADE_IN) scales colours by a
//               0..16 brightness level stepped every FADE_FRAMES frame starts.
//   undefined : level fixed at 16, fade_in/fade_out ignored, fade_busy = 0.
//
// Ports:
//   vga_clk                     pixel clock
//   reset                       synchronous active-high reset
//   DrawX, DrawY                current pixel column / row
//   blank                       1 = active video
//   screen_sel                  requested screen, latched at frame start
//   fade_in, fade_out           single-cycle fade requests
//   rom_addr                    registered ROM address (ROM has 1 clk latency)
//   rom_q                       ROM data
//   pal_idx                     palette index (= rom_q)
//   pal_red/green/blue          palette colour for pal_idx
//   red/green/blue              registered output colour
//   fade_busy                   1 while fading in or out
// -----------------------------------------------------------------------------
module screen_scaler_renderer #(
    parameter int  SRC_W       = 160,
    parameter int  SRC_H       = 120,
    parameter int  DISP_W      = 640,
    parameter int  DISP_H      = 480,
    parameter int  NUM_SCREENS = 2,
    parameter int  ADDR_W      = 16,
    parameter int  IDX_W       = 12,
    parameter int  FADE_FRAMES = 2,
    localparam int SEL_W       = (NUM_SCREENS > 1) ? $clog2(NUM_SCREENS) : 1
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [SEL_W-1:0]  screen_sel,
    input  logic              fade_in,
    input  logic              fade_out,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_idx,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              fade_busy
);

    localparam int XW  = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int YW  = (SRC_H > 1) ? $clog2(SRC_H) : 1;
    localparam int AXW = $clog2(2 * DISP_W);
    localparam int AYW = $clog2(2 * DISP_H);

    localparam logic [9:0]        DISP_W10 = 10'(DISP_W);
    localparam logic [9:0]        DISP_H10 = 10'(DISP_H);
    localparam logic [AXW-1:0]    XSTEP    = AXW'(SRC_W);
    localparam logic [AXW-1:0]    XLIM     = AXW'(DISP_W);
    localparam logic [AYW-1:0]    YSTEP    = AYW'(SRC_H);
    localparam logic [AYW-1:0]    YLIM     = AYW'(DISP_H);
    localparam logic [XW-1:0]     XMAX     = XW'(SRC_W - 1);
    localparam logic [YW-1:0]     YMAX     = YW'(SRC_H - 1);
    localparam logic [ADDR_W-1:0] SCR_SIZE = ADDR_W'(SRC_W * SRC_H);
    localparam logic [ADDR_W-1:0] ROW_SIZE = ADDR_W'(SRC_W);
    localparam logic [SEL_W:0]    NSCR     = (SEL_W + 1)'(NUM_SCREENS);

    // Brightness scaling: (c * level) >> 4, saturating at 15.
    function automatic logic [3:0] scale_c(input logic [3:0] c, input logic [4:0] lvl);
        logic [8:0] prod;
        prod = {5'b0, c} * {4'b0, lvl};
        if (prod[8]) begin
            return 4'hF;
        end
        return prod[7:4];
    endfunction

    logic              in_area;
    logic              frame_start;
    logic              pixel_ok;
    logic [SEL_W-1:0]  scr_in;
    logic [SEL_W-1:0]  scr_cur;
    logic [SEL_W-1:0]  scr_q;
    logic [AXW-1:0]    xacc_q, xacc_d, xsum;
    logic [AYW-1:0]    yacc_q, yacc_d, ysum;
    logic [XW-1:0]     src_x_q, src_x_d;
    logic [YW-1:0]     src_y_q, src_y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              frame_valid_q;
    logic              ok1_q, ok2_q;
    logic [3:0]        red_q, green_q, blue_q;
    logic [3:0]        red_d, green_d, blue_d;
    logic [4:0]        level;

    assign in_area     = (DrawX < DISP_W10) && (DrawY < DISP_H10);
    assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);
    assign scr_in      = ({1'b0, screen_sel} < NSCR) ? screen_sel : '0;
    // The first pixel of a frame already uses the newly requested screen.
    assign scr_cur     = frame_start ? scr_in : scr_q;
    assign pixel_ok    = blank && in_area && (frame_valid_q || frame_start);

    // Column and row DDA. The _d values are the source coordinates of the
    // pixel presented this cycle; the _q values hold the previous pixel's.
    always_comb begin
        xacc_d  = xacc_q;
        src_x_d = src_x_q;
        yacc_d  = yacc_q;
        src_y_d = src_y_q;
        xsum    = xacc_q + XSTEP;
        ysum    = yacc_q + YSTEP;
        if (in_area) begin
            if (DrawX == 10'd0) begin
                xacc_d  = '0;
                src_x_d = '0;
                // Row advances once per line, on its first pixel.
                if (DrawY == 10'd0) begin
                    yacc_d  = '0;
                    src_y_d = '0;
                end else if (ysum >= YLIM) begin
                    yacc_d = ysum - YLIM;
                    if (src_y_q != YMAX) src_y_d = src_y_q + 1'b1;
                end else begin
                    yacc_d = ysum;
                end
            end else if (xsum >= XLIM) begin
                xacc_d = xsum - XLIM;
                if (src_x_q != XMAX) src_x_d = src_x_q + 1'b1;
            end else begin
                xacc_d = xsum;
            end
        end
    end

    always_comb begin
        addr_d = addr_q;
        if (in_area && (frame_valid_q || frame_start)) begin
            addr_d = SCR_SIZE * ADDR_W'(scr_cur) + ROW_SIZE * ADDR_W'(src_y_d)
                   + ADDR_W'(src_x_d);
        end
    end

    always_comb begin
        red_d   = 4'h0;
        green_d = 4'h0;
        blue_d  = 4'h0;
        if (ok2_q) begin
            red_d   = scale_c(pal_red, level);
            green_d = scale_c(pal_green, level);
            blue_d  = scale_c(pal_blue, level);
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            scr_q         <= '0;
            xacc_q        <= '0;
            yacc_q        <= '0;
            src_x_q       <= '0;
            src_y_q       <= '0;
            addr_q        <= '0;
            frame_valid_q <= 1'b0;
            ok1_q         <= 1'b0;
            ok2_q         <= 1'b0;
            red_q         <= 4'h0;
            green_q       <= 4'h0;
            blue_q        <= 4'h0;
        end else begin
            scr_q         <= scr_cur;
            xacc_q        <= xacc_d;
            yacc_q        <= yacc_d;
            src_x_q       <= src_x_d;
            src_y_q       <= src_y_d;
            addr_q        <= addr_d;
            frame_valid_q <= frame_valid_q | frame_start;
            ok1_q         <= pixel_ok;
            ok2_q         <= ok1_q;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
        end
    end

    assign rom_addr = addr_q;
    assign pal_idx  = rom_q;
    assign red      = red_q;
    assign green    = green_q;
    assign blue     = blue_q;

`ifdef SCREEN_FADE_EN
    localparam int FCW = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [FCW-1:0] FCNT_LAST = FCW'(FADE_FRAMES - 1);

    typedef enum logic [1:0] {SHOWN, FADE_OUT, DARK, FADE_IN} fade_state_t;

    fade_state_t    state_q, state_d;
    logic [4:0]     level_q, level_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;

    // A request pulse takes priority over a level step in the same cycle;
    // fade_out beats fade_in, and requests matching the current direction
    // or end state are dropped.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        fcnt_d  = fcnt_q;
        if (fade_out && (state_q == SHOWN || state_q == FADE_IN)) begin
            state_d = FADE_OUT;
            fcnt_d  = '0;
        end else if (!fade_out && fade_in && (state_q == DARK || state_q == FADE_OUT)) begin
            state_d = FADE_IN;
            fcnt_d  = '0;
        end else if (frame_start && (state_q == FADE_OUT || state_q == FADE_IN)) begin
            if (fcnt_q == FCNT_LAST) begin
                fcnt_d = '0;
                if (state_q == FADE_OUT) begin
                    level_d = level_q - 5'd1;
                    if (level_q == 5'd1) state_d = DARK;
                end else begin
                    level_d = level_q + 5'd1;
                    if (level_q == 5'd15) state_d = SHOWN;
                end
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q <= SHOWN;
            level_q <= 5'd16;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign level     = level_q;
    assign fade_busy = (state_q == FADE_OUT) || (state_q == FADE_IN);
`else
    logic unused_fade;
    assign unused_fade = fade_in ^ fade_out ^ (FADE_FRAMES < 1);
    assign level       = 5'd16;
    assign fade_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_screen_scaler_renderer.sv
module tb_screen_scaler_renderer;

    localparam int SRC_W    = 160;
    localparam int SRC_H    = 120;
    localparam int DISP_W   = 640;
    localparam int DISP_H   = 480;
    localparam int NS       = 2;
    localparam int ADDR_W   = 16;
    localparam int IDX_W    = 12;
    localparam int FF       = 1;
    localparam int ST_SHOWN = 0;
    localparam int ST_FO    = 1;
    localparam int ST_DARK  = 2;
    localparam int ST_FI    = 3;

    // ---------------- clock / reset / signals ----------------
    logic              vga_clk = 1'b0;
    logic              reset = 1'b1;
    logic [9:0]        DrawX = '0;
    logic [9:0]        DrawY = '0;
    logic              blank = 1'b0;
    logic [0:0]        screen_sel = '0;
    logic              fade_in = 1'b0;
    logic              fade_out = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [IDX_W-1:0]  rom_q = '0;
    logic [IDX_W-1:0]  pal_idx;
    logic [3:0]        pal_red, pal_green, pal_blue;
    logic [3:0]        red, green, blue;
    logic              fade_busy;
    logic              pal_fixed = 1'b0;

    always #5 vga_clk = ~vga_clk;

    screen_scaler_renderer #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .DISP_W(DISP_W), .DISP_H(DISP_H),
        .NUM_SCREENS(NS), .ADDR_W(ADDR_W), .IDX_W(IDX_W), .FADE_FRAMES(FF)
    ) dut (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .screen_sel(screen_sel), .fade_in(fade_in),
        .fade_out(fade_out), .rom_addr(rom_addr), .rom_q(rom_q),
        .pal_idx(pal_idx), .pal_red(pal_red), .pal_green(pal_green),
        .pal_blue(pal_blue), .red(red), .green(green), .blue(blue),
        .fade_busy(fade_busy)
    );

    // ---------------- environment: ROM and palette ----------------
    function automatic int rom_word(input int a);
        int h;
        h = (a * 37) ^ (a >> 3) ^ 'h5A5;
        return h & ((1 << IDX_W) - 1);
    endfunction

    always @(posedge vga_clk) rom_q <= IDX_W'(rom_word(int'(rom_addr)));

    assign pal_red   = pal_fixed ? 4'hF : pal_idx[3:0];
    assign pal_green = pal_fixed ? 4'h8 : pal_idx[7:4];
    assign pal_blue  = pal_fixed ? 4'h1 : pal_idx[11:8];

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model state
    int  m_addr, m_scr, m_level, m_state, m_cnt;
    bit  m_fvalid;
    logic [12:0] exp_q[$];   // {ok, r, g, b} of pixels still in the pipeline

    function automatic int scale(input int c, input int lvl);
        int v;
        v = (c * lvl) >> 4;
        return (v > 15) ? 15 : v;
    endfunction

    function automatic int pal_of(input int idx);
        if (pal_fixed) return 'hF81;
        return ((idx & 15) << 8) | (((idx >> 4) & 15) << 4) | ((idx >> 8) & 15);
    endfunction

`ifdef SCREEN_FADE_EN
    function automatic void fade_model(input bit fs, input bit fi, input bit fo);
        if (fo && (m_state == ST_SHOWN || m_state == ST_FI)) begin
            m_state = ST_FO; m_cnt = 0;
        end else if (!fo && fi && (m_state == ST_DARK || m_state == ST_FO)) begin
            m_state = ST_FI; m_cnt = 0;
        end else if (fs && (m_state == ST_FO || m_state == ST_FI)) begin
            m_cnt++;
            if (m_cnt == FF) begin
                m_cnt = 0;
                if (m_state == ST_FO) begin
                    m_level--;
                    if (m_level == 0) m_state = ST_DARK;
                end else begin
                    m_level++;
                    if (m_level == 16) m_state = ST_SHOWN;
                end
            end
        end
    endfunction
`endif

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge vga_clk);
        reset = 1'b1; blank = 1'b0; fade_in = 1'b0; fade_out = 1'b0;
        @(posedge vga_clk); #1;
        check("rst_addr", int'(rom_addr), 0);
        check("rst_rgb", int'({red, green, blue}), 0);
        check("rst_busy", int'(fade_busy), 0);
        exp_q.delete();
        exp_q.push_back(13'h0);
        exp_q.push_back(13'h0);
        m_addr = 0; m_scr = 0; m_level = 16; m_state = ST_SHOWN; m_cnt = 0; m_fvalid = 0;
    endtask

    task automatic drive_pix(input int x, input int y, input bit b, input bit fi, input bit fo);
        logic [12:0] head;
        int exp_rgb;
        bit fs, in_area, ok;
        @(negedge vga_clk);
        reset = 1'b0; DrawX = 10'(x); DrawY = 10'(y); blank = b;
        fade_in = fi; fade_out = fo;
        head = exp_q.pop_front();
        exp_rgb = 0;
        if (head[12])
            exp_rgb = (scale(int'(head[11:8]), m_level) << 8)
                    | (scale(int'(head[7:4]), m_level) << 4)
                    |  scale(int'(head[3:0]), m_level);
        fs = (x == 0) && (y == 0);
        in_area = (x < DISP_W) && (y < DISP_H);
        if (fs) m_scr = (int'(screen_sel) < NS) ? int'(screen_sel) : 0;
        ok = b && in_area && (m_fvalid || fs);
        if (in_area && (m_fvalid || fs))
            m_addr = m_scr * SRC_W * SRC_H + ((y * SRC_H) / DISP_H) * SRC_W + (x * SRC_W) / DISP_W;
        if (fs) m_fvalid = 1;
`ifdef SCREEN_FADE_EN
        fade_model(fs, fi, fo);
`endif
        exp_q.push_back({ok, ok ? 12'(pal_of(rom_word(m_addr))) : 12'h0});
        @(posedge vga_clk); #1;
        check("rom_addr", int'(rom_addr), m_addr);
        check("rgb", int'({red, green, blue}), exp_rgb);
        check("fade_busy", int'(fade_busy), int'(m_state == ST_FO || m_state == ST_FI));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_pix(700, 500, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_frame(input int nrows, input int maxlen, input int full_every);
        int len;
        bit fs, fi, fo, b;
        for (int y = 0; y < nrows; y++) begin
            if ($urandom_range(0, 3) == 0) screen_sel = 1'($urandom_range(0, NS - 1));
            len = (full_every > 0 && (y % full_every) == 0) ? DISP_W : int'($urandom_range(1, maxlen));
            for (int x = 0; x < len; x++) begin
                fs = (x == 0) && (y == 0);
                fi = !fs && ($urandom_range(0, 149) == 0);
                fo = !fs && ($urandom_range(0, 149) == 0);
                b  = ($urandom_range(0, 7) != 0);
                drive_pix(x, y, b, fi, fo);
            end
            if ($urandom_range(0, 3) == 0) drive_pix(700 + int'($urandom_range(0, 90)), y, 1'b1, 1'b0, 1'b0);
        end
    endtask

`ifdef SCREEN_FADE_EN
    task automatic tiny_frame(input bit fi_at, input bit fo_at);
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 8; x++)
                drive_pix(x, y, 1'b1, (x == 3 && y == 0) ? fi_at : 1'b0,
                          (x == 3 && y == 0) ? fo_at : 1'b0);
    endtask
`endif

    // ---------------- main sequence ----------------
    initial begin
        int saved;
        do_reset();

        // Frame with screen 0: pixel (4,4) maps to source (1,1).
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < ((y == 4) ? 5 : 8); x++)
                drive_pix(x, y, 1'b1, 1'b0, 1'b0);
        check("addr_x4_y4", int'(rom_addr), 161);

        // screen_sel changes mid-frame; base switches only at next frame start.
        for (int y = 0; y < 5; y++) begin
            if (y == 1) screen_sel = 1'b1;
            for (int x = 0; x < ((y == 4) ? 5 : 8); x++)
                drive_pix(x, y, 1'b1, 1'b0, 1'b0);
        end
        check("addr_keep_scr0", int'(rom_addr), 161);
        drive_pix(0, 0, 1'b1, 1'b0, 1'b0);
        check("addr_scr1_base", int'(rom_addr), 19200);

        // Fixed palette, blank on/off, 3-clock latency.
        idle(3);
        pal_fixed = 1'b1;
        screen_sel = 1'b0;
        drive_pix(0, 0, 1'b1, 1'b0, 1'b0);
        drive_pix(1, 0, 1'b0, 1'b0, 1'b0);
        drive_pix(2, 0, 1'b1, 1'b0, 1'b0);
        check("rgb_blank_on", int'({red, green, blue}), 'hF81);
        drive_pix(3, 0, 1'b1, 1'b0, 1'b0);
        check("rgb_blank_off", int'({red, green, blue}), 0);

        // Outside the active area: address held, pixel black.
        for (int x = 4; x < 8; x++) drive_pix(x, 0, 1'b1, 1'b0, 1'b0);
        saved = int'(rom_addr);
        drive_pix(700, 0, 1'b1, 1'b0, 1'b0);
        drive_pix(701, 0, 1'b1, 1'b0, 1'b0);
        drive_pix(702, 0, 1'b1, 1'b0, 1'b0);
        check("addr_held_outside", int'(rom_addr), saved);
        check("rgb_outside", int'({red, green, blue}), 0);

`ifdef SCREEN_FADE_EN
        tiny_frame(1'b0, 1'b1);
        check("busy_fading_out", int'(fade_busy), 1);
        tiny_frame(1'b0, 1'b0);
        check("fade_l15", int'({red, green, blue}), 'hE70);
        for (int i = 0; i < 15; i++) tiny_frame(1'b0, 1'b0);
        check("dark_rgb", int'({red, green, blue}), 0);
        check("dark_busy", int'(fade_busy), 0);
        tiny_frame(1'b1, 1'b0);
        tiny_frame(1'b0, 1'b0);
        tiny_frame(1'b0, 1'b0);
        tiny_frame(1'b1, 1'b1);
        check("both_pulses_busy", int'(fade_busy), 1);
        tiny_frame(1'b0, 1'b0);
        check("fade_reversed", int'({red, green, blue}), 'h110);
`endif

        idle(3);
        pal_fixed = 1'b0;

        repeat (6) run_frame(int'($urandom_range(2, 8)), 40, 0);
        run_frame(DISP_H, 6, 96);

        // Reset in the middle of a line, then keep scanning that line.
        drive_pix(0, 0, 1'b1, 1'b0, 1'b0);
        for (int x = 1; x < 20; x++) drive_pix(x, 0, 1'b1, 1'b0, 1'b0);
        for (int x = 0; x < 10; x++) drive_pix(x, 1, 1'b1, 1'b0, 1'b0);
        do_reset();
        for (int x = 11; x < 30; x++) drive_pix(x, 1, 1'b1, 1'b0, 1'b0);
        check("black_after_reset", int'({red, green, blue}), 0);

        repeat (4) run_frame(int'($urandom_range(2, 8)), 40, 3);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
